// File: rtl/dsp_mac_pipe.sv
// Four-stage signed multiply-accumulate slice: pre-adder, multiplier, saturating post-adder.
// One global advance enable stalls every stage together under output back-pressure.
module dsp_mac_pipe #(
  parameter int unsigned A_WIDTH = 18,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned P_WIDTH = 48,
  parameter bit          SAT_EN  = 1'b1
) (
  input  logic                      clk,
  input  logic                      RSTN,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [A_WIDTH-1:0] A,
  input  logic signed [B_WIDTH-1:0] B,
  input  logic signed [B_WIDTH-1:0] D,
  input  logic signed [P_WIDTH-1:0] C,
  input  logic        [4:0]         OPMODE,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [P_WIDTH-1:0] P,
  output logic                      OVF
);

  localparam int unsigned XW = B_WIDTH + 1;
  localparam int unsigned MW = A_WIDTH + B_WIDTH + 1;
  localparam int unsigned RW = P_WIDTH + 1;

  localparam logic signed [P_WIDTH-1:0] PMax = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] PMin = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic en;

  // Stage 1: input capture
  logic                      s1_valid_q;
  logic signed [A_WIDTH-1:0] s1_a_q;
  logic signed [B_WIDTH-1:0] s1_b_q;
  logic signed [B_WIDTH-1:0] s1_d_q;
  logic signed [P_WIDTH-1:0] s1_c_q;
  logic        [4:0]         s1_op_q;

  // Stage 2: pre-adder result; op carries only {post_sub, zsel}
  logic                      s2_valid_q;
  logic signed [A_WIDTH-1:0] s2_a_q;
  logic signed [XW-1:0]      s2_x_q;
  logic signed [XW-1:0]      s2_x_d;
  logic signed [P_WIDTH-1:0] s2_c_q;
  logic        [2:0]         s2_op_q;

  // Stage 3: product
  logic                      s3_valid_q;
  logic signed [MW-1:0]      s3_m_q;
  logic signed [MW-1:0]      s3_m_d;
  logic signed [P_WIDTH-1:0] s3_c_q;
  logic        [2:0]         s3_op_q;

  // Stage 4: result / accumulator
  logic                      s4_valid_q;
  logic signed [P_WIDTH-1:0] p_q;
  logic signed [P_WIDTH-1:0] p_d;
  logic                      ovf_q;
  logic                      ovf_d;

  assign en        = !s4_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = s4_valid_q;
  assign P         = p_q;
  assign OVF       = ovf_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_d_q     <= '0;
      s1_c_q     <= '0;
      s1_op_q    <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q  <= A;
        s1_b_q  <= B;
        s1_d_q  <= D;
        s1_c_q  <= C;
        s1_op_q <= OPMODE;
      end
    end
  end

  // Pre-adder is one bit wider than B/D so D+-B never wraps.
  always_comb begin
    logic signed [XW-1:0] b_ext;
    logic signed [XW-1:0] d_ext;
    b_ext = {s1_b_q[B_WIDTH-1], s1_b_q};
    d_ext = {s1_d_q[B_WIDTH-1], s1_d_q};
    s2_x_d = b_ext;
    if (s1_op_q[0]) begin
      s2_x_d = s1_op_q[1] ? (d_ext - b_ext) : (d_ext + b_ext);
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_x_q     <= '0;
      s2_c_q     <= '0;
      s2_op_q    <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_a_q  <= s1_a_q;
        s2_x_q  <= s2_x_d;
        s2_c_q  <= s1_c_q;
        s2_op_q <= s1_op_q[4:2];
      end
    end
  end

  always_comb begin
    logic signed [MW-1:0] a_ext;
    logic signed [MW-1:0] x_ext;
    a_ext  = {{(MW-A_WIDTH){s2_a_q[A_WIDTH-1]}}, s2_a_q};
    x_ext  = {{(MW-XW){s2_x_q[XW-1]}}, s2_x_q};
    s3_m_d = a_ext * x_ext;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s3_valid_q <= 1'b0;
      s3_m_q     <= '0;
      s3_c_q     <= '0;
      s3_op_q    <= '0;
    end else if (en) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_m_q  <= s3_m_d;
        s3_c_q  <= s2_c_q;
        s3_op_q <= s2_op_q;
      end
    end
  end

  // Post-adder evaluated one bit wider than P; top two bits disagreeing means overflow.
  always_comb begin
    logic signed [RW-1:0] m_ext;
    logic signed [RW-1:0] z;
    logic signed [RW-1:0] r;
    m_ext = {{(RW-MW){s3_m_q[MW-1]}}, s3_m_q};
    z     = '0;
    unique case (s3_op_q[1:0])
      2'b01:   z = {s3_c_q[P_WIDTH-1], s3_c_q};
      2'b10:   z = {p_q[P_WIDTH-1], p_q};
      default: z = '0;
    endcase
    r     = s3_op_q[2] ? (z - m_ext) : (z + m_ext);
    ovf_d = r[RW-1] ^ r[RW-2];
    p_d   = r[P_WIDTH-1:0];
    if (SAT_EN && ovf_d) begin
      p_d = r[RW-1] ? PMin : PMax;
    end
  end

  // P/OVF only move on a real result, so bubbles leave the accumulator intact.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s4_valid_q <= 1'b0;
      p_q        <= '0;
      ovf_q      <= 1'b0;
    end else if (en) begin
      s4_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a saturating and a wrapping instance share one stimulus stream,
// checked through a scoreboard fed by a vector table and hand-written multi-cycle sequences.
module tb_dsp_mac_pipe;

  localparam longint MAXP  = (longint'(1) <<< 47) - 1;
  localparam longint MINP  = -(longint'(1) <<< 47);
  localparam longint TWO48 = longint'(1) <<< 48;

  typedef struct {
    longint     a, b, d, c;
    logic [4:0] op;
    bit         mdl;
    longint     ps, pw;
    bit         os, ow;
  } beat_t;

  typedef struct {
    longint ps, pw;
    bit     os, ow;
    int     acc_edge;
    bit     lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               RSTN;
  logic               in_valid;
  logic               out_ready;
  logic signed [17:0] A, B, D;
  logic signed [47:0] C;
  logic        [4:0]  OPMODE;

  logic               in_ready0, out_valid0, OVF0;
  logic signed [47:0] P0;
  logic               in_ready1, out_valid1, OVF1;
  logic signed [47:0] P1;

  int     nvec = 0;
  int     nfail = 0;
  int     edge_cnt = 0;
  int     stall_lo = 1000000;
  int     stall_hi = 1000000;
  int     stall_seen = 0;
  longint acc_s = 0;
  longint acc_w = 0;
  beat_t  cur;
  bit     cur_lat;
  exp_t   q[$];

  always #5 clk = ~clk;

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready0),
    .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE),
    .out_valid(out_valid0), .out_ready(out_ready), .P(P0), .OVF(OVF0)
  );

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready1),
    .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE),
    .out_valid(out_valid1), .out_ready(out_ready), .P(P1), .OVF(OVF1)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic beat_t mk(input longint a, b, d, c, input logic [4:0] op, input bit mdl,
                               input longint ps, pw, input bit os, ow);
    beat_t t;
    t.a = a; t.b = b; t.d = d; t.c = c; t.op = op; t.mdl = mdl;
    t.ps = ps; t.pw = pw; t.os = os; t.ow = ow;
    return t;
  endfunction

  function automatic beat_t acc_beat(input logic [4:0] op);
    return mk(1, 7, 0, 0, op, 1'b1, 0, 0, 1'b0, 1'b0);
  endfunction

  // Reference arithmetic in 64-bit integers, independent of any bit-level trick.
  function automatic void model(input beat_t t, output exp_t e);
    longint x, m, zs, zw, rs, rw;
    x  = t.op[0] ? (t.op[1] ? t.d - t.b : t.d + t.b) : t.b;
    m  = t.a * x;
    zs = (t.op[3:2] == 2'b01) ? t.c : (t.op[3:2] == 2'b10) ? acc_s : 0;
    zw = (t.op[3:2] == 2'b01) ? t.c : (t.op[3:2] == 2'b10) ? acc_w : 0;
    rs = t.op[4] ? zs - m : zs + m;
    rw = t.op[4] ? zw - m : zw + m;
    e.os = (rs > MAXP) || (rs < MINP);
    e.ow = (rw > MAXP) || (rw < MINP);
    e.ps = (rs > MAXP) ? MAXP : (rs < MINP) ? MINP : rs;
    e.pw = (rw > MAXP) ? rw - TWO48 : (rw < MINP) ? rw + TWO48 : rw;
  endfunction

  task automatic push();
    exp_t e;
    if (cur.mdl) model(cur, e);
    else begin
      e.ps = cur.ps; e.pw = cur.pw; e.os = cur.os; e.ow = cur.ow;
    end
    e.acc_edge = edge_cnt + 1;
    e.lat = cur_lat;
    acc_s = e.ps;
    acc_w = e.pw;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      nvec++; nfail++;
      $display("FAIL spurious_out: got out_valid=1, want no result pending (edge %0d)", edge_cnt);
      return;
    end
    e = q.pop_front();
    chk("p_sat", P0, e.ps);
    chk("ovf_sat", OVF0, e.os);
    chk("p_wrap", P1, e.pw);
    chk("ovf_wrap", OVF1, e.ow);
    chk("valid_wrap", out_valid1, 1);
    if (e.lat) chk("latency", edge_cnt - e.acc_edge, 3);
  endtask

  // One clock: drive out_ready, settle, check/consume output, record acceptance, advance.
  task automatic cycle(output bit took);
    out_ready = !(edge_cnt >= stall_lo && edge_cnt <= stall_hi);
    #1;
    if (out_valid0 && !out_ready) begin
      stall_seen++;
      chk("stall_in_ready", in_ready0, 0);
      if (q.size() != 0) chk("stall_p_hold", P0, q[0].ps);
    end
    if (out_valid0 && out_ready) pop_check();
    took = in_valid && in_ready0;
    if (took) push();
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic send(input beat_t t, input bit lat);
    bit took = 1'b0;
    cur = t; cur_lat = lat;
    A = t.a[17:0]; B = t.b[17:0]; D = t.d[17:0]; C = t.c[47:0]; OPMODE = t.op;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !took; i++) cycle(took);
    in_valid = 1'b0;
    if (!took) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit took;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(took);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    cycle(took);
  endtask

  beat_t tab[14];

  initial begin
    bit took;
    tab[0]  = mk(3, 5, 0, 0, 5'b00000, 0, 15, 15, 0, 0);
    tab[1]  = mk(3, 5, 0, 0, 5'b00000, 0, 15, 15, 0, 0);
    tab[2]  = mk(3, 5, 0, 0, 5'b00000, 0, 15, 15, 0, 0);
    tab[3]  = mk(3, 5, 0, 0, 5'b00000, 0, 15, 15, 0, 0);
    tab[4]  = mk(-2, 4, 10, 100, 5'b10111, 0, 112, 112, 0, 0);
    tab[5]  = mk(-2, 4, 10, 100, 5'b11111, 0, 12, 12, 0, 0);
    tab[6]  = mk(5, 7, -3, 0, 5'b00001, 0, 20, 20, 0, 0);
    tab[7]  = mk(4, -6, 100, 0, 5'b00010, 0, -24, -24, 0, 0);
    tab[8]  = mk(1, 1, 0, MAXP, 5'b00100, 0, MAXP, MINP, 1, 1);
    tab[9]  = mk(1, 1, 0, MINP, 5'b10100, 0, MINP, MAXP, 1, 1);
    tab[10] = mk(-131072, -131072, 0, 0, 5'b00000, 0, 64'sd17179869184, 64'sd17179869184, 0, 0);
    tab[11] = mk(-131072, 131071, -131072, 0, 5'b00011, 0,
                 64'sd34359607296, 64'sd34359607296, 0, 0);
    tab[12] = mk(7, 8, 0, -1000, 5'b00100, 0, -944, -944, 0, 0);
    tab[13] = mk(-1, 1, 0, MINP, 5'b10100, 0, MINP + 1, MINP + 1, 0, 0);

    RSTN = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; D = '0; C = '0; OPMODE = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p", P0, 0);
    chk("rst_ovf", OVF0, 0);
    chk("rst_out_valid", out_valid0, 0);
    RSTN = 1'b1;
    #1;
    chk("rst_in_ready", in_ready0, 1);

    foreach (tab[i]) send(tab[i], 1'b1);
    drain();

    // Accumulate 7, 14, ..., 70 on consecutive cycles.
    send(acc_beat(5'b00000), 1'b1);
    for (int i = 0; i < 9; i++) send(acc_beat(5'b01000), 1'b1);
    drain();
    chk("acc_final", P0, 70);

    // Back-pressure: 3 stall cycles while results are pending.
    stall_lo = edge_cnt + 6;
    stall_hi = edge_cnt + 8;
    stall_seen = 0;
    send(acc_beat(5'b00000), 1'b0);
    for (int i = 0; i < 5; i++) send(acc_beat(5'b01000), 1'b0);
    drain();
    stall_lo = 1000000; stall_hi = 1000000;
    chk("stall_cycles", stall_seen, 3);
    chk("bp_final", P0, 42);

    // Reset with 3 beats in flight and P=70.
    send(acc_beat(5'b00000), 1'b1);
    for (int i = 0; i < 9; i++) send(acc_beat(5'b01000), 1'b1);
    drain();
    for (int i = 0; i < 3; i++) send(acc_beat(5'b01000), 1'b0);
    chk("pre_rst_valid", out_valid0, 0);
    chk("pre_rst_p", P0, 70);
    RSTN = 1'b0;
    #1;
    chk("midrst_p", P0, 0);
    chk("midrst_ovf", OVF0, 0);
    chk("midrst_valid", out_valid0, 0);
    chk("midrst_p_wrap", P1, 0);
    q.delete();
    acc_s = 0; acc_w = 0;
    cycle(took);
    cycle(took);
    chk("midrst_hold_valid", out_valid0, 0);
    RSTN = 1'b1;
    send(acc_beat(5'b01000), 1'b1);
    drain();
    chk("post_rst_p", P0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1);
  end

endmodule
